sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The parameter list SHALL be: NUM_REQ, 4, number of requesters (0=record, 1=play, 2=mix, 3=pitch).
REQ-002 The parameter list SHALL be: ADDR_W, 20, SRAM word address width.
REQ-003 The parameter list SHALL be: DATA_W, 16, SRAM data width.
REQ-004 The parameter list SHALL be: ACC_CYC, 2, cycles the SRAM bus is held per access (legal range 1-7).
REQ-005 The ports SHALL be: i_clk  in  1  clock (single domain); reset is synchronous and active-high.
REQ-006 The ports SHALL be: i_rst  in  1  synchronous active-high reset.
REQ-007 The ports SHALL be: req  in  NUM_REQ  per-requester access request.
REQ-008 The ports SHALL be: we  in  NUM_REQ  per-requester write enable (1=write, 0=read).
REQ-009 The ports SHALL be: addr  in  NUM_REQ*ADDR_W  packed addresses, requester k at bits [k*ADDR_W +: ADDR_W].
REQ-010 The ports SHALL be: wdata  in  NUM_REQ*DATA_W  packed write data, same packing.
REQ-011 The ports SHALL be: ack  out  NUM_REQ  one-cycle completion pulse per requester.
REQ-012 The ports SHALL be: rdata  out  DATA_W  read data, valid only in the ack cycle of a read.
REQ-013 The ports SHALL be: sram_addr  out  ADDR_W  SRAM address.
REQ-014 The ports SHALL be: sram_wdata  out  DATA_W  SRAM write data; sram_wdata_oe  out  1  tristate enable.
REQ-015 The ports SHALL be: sram_rdata  in  DATA_W  SRAM read data.
REQ-016 The ports SHALL be: sram_ce_n, sram_oe_n, sram_we_n  out  1 each  active-low SRAM strobes.
REQ-017 The ports SHALL be: busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-018 The block SHALL implement an FSM with the states IDLE, ACCESS and DONE.
REQ-019 In IDLE with any req bit high, the block SHALL latch the round-robin winner's index, we, addr and wdata, and enter ACCESS on the next cycle.
REQ-020 Arbitration SHALL be round-robin: the search starts at ptr, ptr resets to 0, and on each grant ptr becomes (winner+1) mod NUM_REQ.
REQ-021 When several requests are simultaneous, the first requester at or after ptr in ascending wrapped order SHALL win.
REQ-022 ACCESS SHALL last exactly ACC_CYC cycles under a down-counter, driving sram_addr, sram_ce_n=0 and the latched strobes throughout.
REQ-023 For a write in ACCESS, the block SHALL drive sram_we_n=0, sram_oe_n=1 and sram_wdata_oe=1.
REQ-024 For a read in ACCESS, the block SHALL drive sram_oe_n=0, sram_we_n=1 and sram_wdata_oe=0.
REQ-025 On the last ACCESS cycle of a read, the block SHALL register sram_rdata into rdata.
REQ-026 DONE SHALL last one cycle: ack[winner]=1, all strobes deasserted (high), then the FSM returns to IDLE.
REQ-027 Request-to-ack latency SHALL be ACC_CYC+2 cycles when the bus is free, and the next grant SHALL be evaluated in the cycle after DONE.
REQ-028 Requesters SHALL hold req, we, addr and wdata stable until ack; the block samples them only at grant.
REQ-029 A requester that keeps req high after ack SHALL be treated as making a new request, so back-to-back access is allowed subject to round-robin.
REQ-030 A req deasserted while not granted SHALL be ignored, and a req deasserted after grant SHALL not abort the access.
REQ-031 The block SHALL never assert more than one ack bit in any cycle.
REQ-032 Outside ACCESS the block SHALL keep sram_ce_n, sram_oe_n and sram_we_n at 1 and sram_wdata_oe at 0.
REQ-033 rdata SHALL hold its last value outside read acks.

Reset
REQ-034 While i_rst is high at a clock edge, the block SHALL enter IDLE with ptr=0, counter=0, ack=0, rdata=0, busy=0, sram_addr=0, sram_wdata=0, sram_wdata_oe=0 and all strobes high.
REQ-035 A reset during ACCESS or DONE SHALL abort the transfer with no ack issued, and strobes SHALL go high on the same edge.

Structure
REQ-036 The FSM state enum, the requester index constants (REQ_REC=0, REQ_PLAY=1, REQ_MIX=2, REQ_PITCH=3) and the default widths SHALL live in the shared project package.
REQ-037 The round-robin winner search SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs winner index and a valid bit).
REQ-038 Every SRAM-facing output SHALL be driven from a register.

Verification
REQ-039 The bench SHALL check a single read: req=4'b0010, addr[1]=0x00123, sram_rdata=0xBEEF -> sram_addr=0x00123 and oe_n=0 for 2 cycles, then ack=4'b0010 with rdata=0xBEEF at cycle 4.
REQ-040 The bench SHALL check a single write: req=4'b0001, we=1, wdata[0]=0x1234 -> we_n=0, sram_wdata_oe=1, sram_wdata=0x1234 for 2 cycles, then ack=4'b0001.
REQ-041 The bench SHALL check a continuous contention: req=4'b1111 held high, ptr=0 -> ack order 0,1,2,3,0, one ack every 4 cycles.
REQ-042 The bench SHALL check a pointer wrap: ptr=3 with req=4'b1001 -> requester 3 is granted first, then requester 0.
REQ-043 The bench SHALL check a reset mid-access: i_rst pulsed on the 1st ACCESS cycle -> no ack, strobes high the next cycle, ptr=0, and the next request is served normally.
REQ-044 The bench SHALL check an ACC_CYC=1 build: a single read yields ack at cycle 3 and one-hot ack holds throughout a random-traffic run.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Widths, requester ids and the arbiter FSM encoding.
package sram_arbiter_pkg;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 20;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_ACC_CYC = 2;
   localparam int CNT_W       = 3;

   localparam int REQ_REC   = 0;
   localparam int REQ_PLAY  = 1;
   localparam int REQ_MIX   = 2;
   localparam int REQ_PITCH = 3;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   function automatic int ptr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sram_arbiter_rr_pick.sv
// Round-robin winner search for the SRAM arbiter.
// Picks the first set req bit at or after ptr, wrapping.
module rr_pick
   import sram_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int PTR_W   = ptr_w(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               valid
);

   logic [NUM_REQ-1:0] rot;
   logic [PTR_W:0]     sum;

   // rotate so bit 0 is ptr; lowest set bit of rot wins
   always_comb begin
      rot    = NUM_REQ'({req, req} >> ptr);
      sum    = '0;
      winner = '0;
      valid  = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(NUM_REQ)) begin
               sum = sum - (PTR_W + 1)'(NUM_REQ);
            end
            winner = sum[PTR_W-1:0];
            valid  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one async SRAM between requesters.
// IDLE grants, ACCESS holds the bus ACC_CYC cycles, DONE acks.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ACC_CYC = DEF_ACC_CYC
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        we,
   input  logic [NUM_REQ*ADDR_W-1:0] addr,
   input  logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0]        ack,
   output logic [DATA_W-1:0]         rdata,
   output logic [ADDR_W-1:0]         sram_addr,
   output logic [DATA_W-1:0]         sram_wdata,
   output logic                      sram_wdata_oe,
   input  logic [DATA_W-1:0]         sram_rdata,
   output logic                      sram_ce_n,
   output logic                      sram_oe_n,
   output logic                      sram_we_n,
   output logic                      busy
);

   localparam int PTR_W = ptr_w(NUM_REQ);

   state_t             state;
   logic [PTR_W-1:0]   ptr;
   logic [PTR_W-1:0]   win;
   logic [CNT_W-1:0]   cnt;
   logic               lat_we;

   logic [PTR_W-1:0]   pick;
   logic               pick_v;
   logic [PTR_W-1:0]   nxt_ptr;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;
   logic               sel_we;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick),
      .valid  (pick_v)
   );

   assign nxt_ptr = (pick == PTR_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
   assign busy    = (state != S_IDLE);

   // mux out the candidate winner's request fields
   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_we    = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (pick == PTR_W'(k)) begin
            sel_addr  = addr[k*ADDR_W +: ADDR_W];
            sel_wdata = wdata[k*DATA_W +: DATA_W];
            sel_we    = we[k];
         end
      end
   end

   // arbiter FSM with registered SRAM strobes, ack and rdata
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= S_IDLE;
         ptr           <= '0;
         win           <= '0;
         cnt           <= '0;
         lat_we        <= 1'b0;
         ack           <= '0;
         rdata         <= '0;
         sram_addr     <= '0;
         sram_wdata    <= '0;
         sram_wdata_oe <= 1'b0;
         sram_ce_n     <= 1'b1;
         sram_oe_n     <= 1'b1;
         sram_we_n     <= 1'b1;
      end else begin
         ack <= '0;
         unique case (state)
            S_IDLE: begin
               if (pick_v) begin
                  win           <= pick;
                  ptr           <= nxt_ptr;
                  lat_we        <= sel_we;
                  sram_addr     <= sel_addr;
                  sram_wdata    <= sel_wdata;
                  cnt           <= CNT_W'(ACC_CYC);
                  sram_ce_n     <= 1'b0;
                  sram_we_n     <= ~sel_we;
                  sram_oe_n     <= sel_we;
                  sram_wdata_oe <= sel_we;
                  state         <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  sram_ce_n     <= 1'b1;
                  sram_oe_n     <= 1'b1;
                  sram_we_n     <= 1'b1;
                  sram_wdata_oe <= 1'b0;
                  ack[win]      <= 1'b1;
                  if (!lat_we) begin
                     rdata <= sram_rdata;
                  end
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and random checks for sram_arbiter.
// Two builds: ACC_CYC=2 (directed) and ACC_CYC=1 (random traffic).
module tb_sram_arbiter;

   logic clk = 1'b0;
   logic i_rst = 1'b1;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // build A: ACC_CYC = 2
   logic [3:0]  req_a = '0, we_a = '0;
   logic [79:0] addr_a = '0;
   logic [63:0] wdata_a = '0;
   logic [15:0] srd_a = '0;
   logic [3:0]  ack_a;
   logic [15:0] rdata_a, swd_a;
   logic [19:0] saddr_a;
   logic        swoe_a, ce_a, oe_a, wen_a, busy_a;

   // build B: ACC_CYC = 1
   logic [3:0]  req_b = '0, we_b = '0;
   logic [79:0] addr_b = '0;
   logic [63:0] wdata_b = '0;
   logic [15:0] srd_b;
   logic [3:0]  ack_b;
   logic [15:0] rdata_b, swd_b;
   logic [19:0] saddr_b;
   logic        swoe_b, ce_b, oe_b, wen_b, busy_b;

   sram_arbiter #(.ACC_CYC(2)) dut_a (
      .i_clk(clk), .i_rst(i_rst),
      .req(req_a), .we(we_a), .addr(addr_a), .wdata(wdata_a),
      .ack(ack_a), .rdata(rdata_a),
      .sram_addr(saddr_a), .sram_wdata(swd_a),
      .sram_wdata_oe(swoe_a), .sram_rdata(srd_a),
      .sram_ce_n(ce_a), .sram_oe_n(oe_a), .sram_we_n(wen_a),
      .busy(busy_a)
   );

   sram_arbiter #(.ACC_CYC(1)) dut_b (
      .i_clk(clk), .i_rst(i_rst),
      .req(req_b), .we(we_b), .addr(addr_b), .wdata(wdata_b),
      .ack(ack_b), .rdata(rdata_b),
      .sram_addr(saddr_b), .sram_wdata(swd_b),
      .sram_wdata_oe(swoe_b), .sram_rdata(srd_b),
      .sram_ce_n(ce_b), .sram_oe_n(oe_b), .sram_we_n(wen_b),
      .busy(busy_b)
   );

   function automatic logic [15:0] init_val(input int i);
      return 16'(i * 32'h1111) ^ 16'h5A5A;
   endfunction

   // behavioural SRAM behind build B
   logic [15:0] mem_b [16];
   assign srd_b = oe_b ? 16'hDEAD : mem_b[saddr_b[3:0]];
   always @(posedge clk) begin
      if (i_rst) begin
         for (int i = 0; i < 16; i++) mem_b[i] <= init_val(i);
      end else if (!ce_b && !wen_b) begin
         mem_b[saddr_b[3:0]] <= swd_b;
      end
   end

   // reference model state (transaction level)
   logic [15:0] ref_mem [16];
   int          m_ptr, m_win, m_free, m_ack_at;
   logic        m_we;
   logic [3:0]  m_addr;
   logic [15:0] m_wdata;
   logic [3:0]  last_ack, exp4;
   int          ord [5] = '{0, 1, 2, 3, 0};

   function automatic int rr(input logic [3:0] r, input int p);
      for (int i = 0; i < 4; i++) begin
         if (r[(p + i) % 4]) return (p + i) % 4;
      end
      return -1;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // strobes as {ce_n, oe_n, we_n, wdata_oe}
   task automatic bus_a(input string tag, input logic [3:0] e);
      chk(tag, {28'b0, ce_a, oe_a, wen_a, swoe_a}, {28'b0, e});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_req(input int k);
      req_b[k] = 1'b1;
      we_b[k]  = 1'($urandom_range(0, 1));
      addr_b[k*20 +: 20]  = 20'($urandom_range(0, 15));
      wdata_b[k*16 +: 16] = 16'($urandom);
   endtask

   localparam logic [3:0] IDLE_S = 4'b1110;
   localparam logic [3:0] RD_S   = 4'b0010;
   localparam logic [3:0] WR_S   = 4'b0101;

   initial begin
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ack", ack_a, 0);
      chk("rst_rdata", rdata_a, 0);
      chk("rst_busy", busy_a, 0);
      chk("rst_saddr", saddr_a, 0);
      chk("rst_swdata", swd_a, 0);
      bus_a("rst_bus", IDLE_S);
      chk("rst_ack_b", ack_b, 0);
      tick();
      i_rst = 1'b0;

      // single read, requester 1
      tick();
      req_a = 4'b0010;
      addr_a[20 +: 20] = 20'h00123;
      srd_a = 16'hBEEF;
      @(negedge clk);
      chk("rd_c1_busy", busy_a, 0);
      chk("rd_c1_ack", ack_a, 0);
      for (int c = 2; c <= 3; c++) begin
         tick();
         @(negedge clk);
         chk("rd_addr", saddr_a, 20'h00123);
         bus_a("rd_bus", RD_S);
         chk("rd_ack_lo", ack_a, 0);
      end
      tick();
      @(negedge clk);
      chk("rd_ack", ack_a, 4'b0010);
      chk("rd_rdata", rdata_a, 16'hBEEF);
      bus_a("rd_done_bus", IDLE_S);
      tick();
      req_a = 4'b0000;
      srd_a = 16'h0BAD;
      @(negedge clk);
      chk("rd_post_ack", ack_a, 0);
      chk("rd_post_busy", busy_a, 0);

      // single write, requester 0
      tick();
      req_a = 4'b0001;
      we_a = 4'b0001;
      addr_a[0 +: 20] = 20'h00456;
      wdata_a[0 +: 16] = 16'h1234;
      @(negedge clk);
      chk("wr_c1_ack", ack_a, 0);
      for (int c = 2; c <= 3; c++) begin
         tick();
         @(negedge clk);
         bus_a("wr_bus", WR_S);
         chk("wr_wdata", swd_a, 16'h1234);
         chk("wr_addr", saddr_a, 20'h00456);
      end
      tick();
      @(negedge clk);
      chk("wr_ack", ack_a, 4'b0001);
      chk("wr_rdata_hold", rdata_a, 16'hBEEF);
      bus_a("wr_done_bus", IDLE_S);
      tick();
      req_a = 4'b0000;
      we_a = 4'b0000;

      // full contention from ptr = 0
      tick();
      i_rst = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         if (c == 1) begin
            i_rst = 1'b0;
            req_a = 4'b1111;
         end
         @(negedge clk);
         exp4 = (c % 4 == 0) ? 4'(4'b0001 << ord[c/4-1]) : 4'b0000;
         chk($sformatf("cont_c%0d", c), ack_a, exp4);
      end
      tick();
      req_a = 4'b0000;

      // move ptr to 3, then check the wrap with 4'b1001
      tick();
      req_a = 4'b0100;
      repeat (3) tick();
      @(negedge clk);
      chk("wrap_pre_ack", ack_a, 4'b0100);
      for (int c = 1; c <= 8; c++) begin
         tick();
         if (c == 1) req_a = 4'b1001;
         @(negedge clk);
         exp4 = (c == 4) ? 4'b1000 : (c == 8) ? 4'b0001 : 4'b0000;
         chk($sformatf("wrap_c%0d", c), ack_a, exp4);
      end
      tick();
      req_a = 4'b0000;

      // reset during the first ACCESS cycle
      tick();
      req_a = 4'b0100;
      @(negedge clk);
      tick();
      i_rst = 1'b1;
      @(negedge clk);
      bus_a("mid_access_bus", RD_S);
      tick();
      i_rst = 1'b0;
      req_a = 4'b0000;
      @(negedge clk);
      bus_a("mid_rst_bus", IDLE_S);
      chk("mid_rst_busy", busy_a, 0);
      chk("mid_rst_rdata", rdata_a, 0);
      for (int c = 4; c <= 7; c++) begin
         tick();
         @(negedge clk);
         chk("mid_rst_noack", ack_a, 0);
      end
      tick();
      req_a = 4'b1010;
      srd_a = 16'hC0DE;
      repeat (3) tick();
      @(negedge clk);
      chk("post_rst_ack", ack_a, 4'b0010);
      chk("post_rst_rdata", rdata_a, 16'hC0DE);
      tick();
      req_a = 4'b0000;

      // ACC_CYC=1 single read: ack at cycle 3
      tick();
      req_b = 4'b0001;
      addr_b[0 +: 20] = 20'd3;
      @(negedge clk);
      chk("b_c1_ack", ack_b, 0);
      tick();
      @(negedge clk);
      chk("b_c2_ack", ack_b, 0);
      chk("b_c2_oe", oe_b, 0);
      tick();
      @(negedge clk);
      chk("b_c3_ack", ack_b, 4'b0001);
      chk("b_c3_rdata", rdata_b, init_val(3));
      tick();
      req_b = 4'b0000;

      // random traffic on ACC_CYC=1 against the model
      tick();
      i_rst = 1'b1;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      m_ptr = 0;
      m_free = 0;
      m_ack_at = -1;
      last_ack = '0;
      for (int t = 0; t < 400; t++) begin
         tick();
         if (t == 0) i_rst = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (last_ack[k]) begin
               if ($urandom_range(0, 1) == 1) new_req(k);
               else req_b[k] = 1'b0;
            end else if (!req_b[k] && $urandom_range(0, 3) == 0) begin
               new_req(k);
            end
         end
         @(negedge clk);
         exp4 = (t == m_ack_at) ? 4'(4'b0001 << m_win) : 4'b0000;
         chk("rnd_ack", ack_b, exp4);
         chk("rnd_onehot", $onehot0(ack_b), 1);
         if (t == m_ack_at) begin
            if (!m_we) chk("rnd_rdata", rdata_b, ref_mem[m_addr]);
            else ref_mem[m_addr] = m_wdata;
         end
         if (t >= m_free && req_b != 4'b0000) begin
            m_win    = rr(req_b, m_ptr);
            m_ptr    = (m_win + 1) % 4;
            m_we     = we_b[m_win];
            m_addr   = addr_b[m_win*20 +: 4];
            m_wdata  = wdata_b[m_win*16 +: 16];
            m_ack_at = t + 2;
            m_free   = t + 3;
         end
         last_ack = ack_b;
      end
      tick();
      req_b = 4'b0000;

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
